sprite_redraw_engine: RTL and testbench
=======================================

Name: sprite_redraw_engine

Overview:
- Pixel-write source sitting directly upstream of the VGA adapter at 320x240 with 3-bit colour.
- On a move request it first erases the sprite's old footprint by repainting background pixels read from a background ROM.
- It then steps the sprite position one increment per axis, clamped to the screen, and draws the sprite from a sprite ROM, skipping transparent pixels.
- Its x/y/colour/plot outputs drive the adapter's pixel-write port directly.

Parameters:
SPRITE_W, 8, sprite width in pixels (power of 2)
SPRITE_H, 8, sprite height in pixels (power of 2)
SCREEN_W, 320, screen width in pixels
SCREEN_H, 240, screen height in pixels
STEP, 4, pixels moved per axis per request
X_START, 0, x position after reset
Y_START, 0, y position after reset
TRANSPARENT, 3'b101, sprite ROM colour value that is never plotted

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetn  input  1  asynchronous active-low reset
req  input  1  move request; sampled only in IDLE
dir  input  2  dir[1]: 0=left, 1=right; dir[0]: 0=down (+y), 1=up (-y)
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when a redraw completes
bg_addr  output  17  background ROM address, y*320+x
bg_data  input  3  background ROM data, 1-cycle synchronous latency
spr_addr  output  log2(SPRITE_W*SPRITE_H)  sprite ROM address, row*SPRITE_W+col
spr_data  input  3  sprite ROM data, 1-cycle synchronous latency
x  output  9  pixel x coordinate to the adapter
y  output  8  pixel y coordinate to the adapter
colour  output  3  pixel colour to the adapter
plot  output  1  pixel write strobe to the adapter
pos_x  output  9  current sprite top-left x
pos_y  output  8  current sprite top-left y

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=INIT_DRAW; pos=(X_START,Y_START); counters=0.
  - plot=0, done=0, busy=1; x=0, y=0, colour=0.
  - Takes effect immediately, including mid-operation; no partial pixel is emitted after reset asserts.
- States: INIT_DRAW, IDLE, ERASE, UPDATE, DRAW, FINISH.
  - INIT_DRAW behaves exactly like DRAW, so the sprite appears after reset. It then goes to FINISH.
- IDLE:
  - busy=0, plot=0.
  - req=1 at an edge moves to ERASE; dir is latched at that edge.
  - req while not in IDLE is ignored (not queued).
- Pixel scan (ERASE/DRAW):
  - Column counter runs 0..SPRITE_W-1 inner, row counter 0..SPRITE_H-1 outer, one pixel per cycle.
  - The address is issued in cycle n. x/y/colour/plot are registered in cycle n+1, using the delayed (col,row) so the coordinates align with the ROM data.
  - A one-cycle flush follows the last address, so each scan lasts SPRITE_W*SPRITE_H+1 cycles.
- ERASE:
  - bg_addr = ((pos_y+row)<<8) + ((pos_y+row)<<6) + (pos_x+col).
  - colour=bg_data; plot=1 for all 64 pixels.
  - After the flush, go to UPDATE.
- UPDATE (1 cycle, plot=0):
  - new_x = pos_x ± STEP.
  - Clamp: if the result would be <0, use 0; if >SCREEN_W-SPRITE_W (312), use 312.
  - Same for y with limit SCREEN_H-SPRITE_H (232).
  - Compute in signed 11-bit to detect underflow.
  - Position registers update at the end of UPDATE.
- DRAW:
  - spr_addr = row*SPRITE_W+col; colour=spr_data.
  - plot=1 only if spr_data != TRANSPARENT; x/y track regardless.
  - After the flush, go to FINISH.
- FINISH (1 cycle): done=1, busy=0, then IDLE.
- Latency: req accepted at edge k gives a done pulse in cycle k+1+65+1+65.
- Clamped no-op move: still performs a full erase and redraw.
- Outside ERASE/DRAW output cycles, plot=0 and x/y/colour hold their last values.

Decomposition:
- Shared package (monument_pkg):
  - SCREEN_W/H, colour width 3, TRANSPARENT value.
  - State enum.
  - Function for y*320+x as (y<<8)+(y<<6)+x.
- One natural sub-module: sprite_scan_counter, the col/row counter with a last-pixel flag plus one-stage delayed (col,row,valid). It is instanced once and restarted for each scan.

Test Plan:
- Reset release → INIT_DRAW: 64 candidate cycles at pos (0,0), transparent pixels unplotted; done pulse; busy=0; pos=(0,0).
- From (100,50), req with dir=2'b10 (right, down):
  - 64 erase plots at x 100..107, y 50..57, each colour equal to the background model at y*320+x.
  - Then draw at (104,54); done 132 cycles after acceptance.
- Clamp, left/up: at (2,2), dir=2'b01 → pos becomes (0,0).
- Clamp, right/down: at (310,230), dir=2'b10 → pos becomes (312,232).
- req held high for the whole operation → exactly one move; a req pulse during busy is ignored; pos changes by one STEP only.
- resetn pulsed low mid-ERASE → plot drops to 0 asynchronously; pos=(X_START,Y_START); INIT_DRAW reruns from pixel 0.

Source files
------------

// File: rtl/monument_pkg.sv
// Shared screen geometry, colour encoding, engine states and the framebuffer
// address helper for the sprite redraw engine.
package monument_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 240;
    localparam int unsigned COLOUR_W      = 3;
    localparam int unsigned X_W           = 9;
    localparam int unsigned Y_W           = 8;
    localparam int unsigned BG_ADDR_W     = 17;

    localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 3'b101;

    typedef enum logic [2:0] {
        S_INIT_DRAW,
        S_IDLE,
        S_ERASE,
        S_UPDATE,
        S_DRAW,
        S_FINISH
    } state_t;

    // y*320+x built from shifts so no multiplier is needed
    function automatic logic [BG_ADDR_W-1:0] pixel_addr(input logic [Y_W-1:0] py,
                                                        input logic [X_W-1:0] px);
        return (BG_ADDR_W'(py) << 8) + (BG_ADDR_W'(py) << 6) + BG_ADDR_W'(px);
    endfunction

endpackage

// File: rtl/sprite_redraw_engine_scan.sv
// Column/row raster counter over the sprite footprint, with a one-stage
// delayed copy that lines up with synchronous ROM data.
module sprite_scan_counter #(
    parameter int unsigned COLS = 8,
    parameter int unsigned ROWS = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    output logic [$clog2(COLS)-1:0]   col,
    output logic [$clog2(ROWS)-1:0]   row,
    output logic                      active,
    output logic [$clog2(COLS)-1:0]   col_d,
    output logic [$clog2(ROWS)-1:0]   row_d,
    output logic                      valid_d
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    logic last_c;
    assign last_c = active && (col == COL_MAX) && (row == ROW_MAX);

    // Comes out of reset already scanning so the first draw needs no start pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col     <= '0;
            row     <= '0;
            active  <= 1'b1;
            col_d   <= '0;
            row_d   <= '0;
            valid_d <= 1'b0;
        end else begin
            col_d   <= col;
            row_d   <= row;
            valid_d <= active;
            if (start) begin
                col    <= '0;
                row    <= '0;
                active <= 1'b1;
            end else if (active) begin
                if (last_c) begin
                    active <= 1'b0;
                    col    <= '0;
                end else if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sprite_redraw_engine.sv
// Sprite redraw engine: erases the old sprite footprint from the background ROM,
// steps the position one increment per axis (clamped), then redraws the sprite.
module sprite_redraw_engine
    import monument_pkg::*;
#(
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned SPRITE_H = 8,
    parameter int unsigned SCREEN_W = SCREEN_WIDTH,
    parameter int unsigned SCREEN_H = SCREEN_HEIGHT,
    parameter int unsigned STEP     = 4,
    parameter int unsigned X_START  = 0,
    parameter int unsigned Y_START  = 0,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_COLOUR
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic                                   req,
    input  logic [1:0]                             dir,
    output logic                                   busy,
    output logic                                   done,
    output logic [BG_ADDR_W-1:0]                   bg_addr,
    input  logic [COLOUR_W-1:0]                    bg_data,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]   spr_addr,
    input  logic [COLOUR_W-1:0]                    spr_data,
    output logic [X_W-1:0]                         x,
    output logic [Y_W-1:0]                         y,
    output logic [COLOUR_W-1:0]                    colour,
    output logic                                   plot,
    output logic [X_W-1:0]                         pos_x,
    output logic [Y_W-1:0]                         pos_y
);

    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);
    localparam int unsigned SPR_AW = $clog2(SPRITE_W * SPRITE_H);
    localparam int unsigned MAX_X  = SCREEN_W - SPRITE_W;
    localparam int unsigned MAX_Y  = SCREEN_H - SPRITE_H;
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] MAX_X_S = 11'(MAX_X);
    localparam logic signed [10:0] MAX_Y_S = 11'(MAX_Y);

    state_t             state;
    logic [1:0]         dir_q;
    logic [COL_W-1:0]   col, col_d;
    logic [ROW_W-1:0]   row, row_d;
    logic               scan_active, valid_d;
    logic               scan_start_c;
    logic signed [10:0] nx_c, ny_c;
    logic [X_W-1:0]     next_x_c;
    logic [Y_W-1:0]     next_y_c;

    assign scan_start_c = ((state == S_IDLE) && req) || (state == S_UPDATE);

    sprite_scan_counter #(
        .COLS (SPRITE_W),
        .ROWS (SPRITE_H)
    ) u_scan (
        .clock   (clock),
        .resetn  (resetn),
        .start   (scan_start_c),
        .col     (col),
        .row     (row),
        .active  (scan_active),
        .col_d   (col_d),
        .row_d   (row_d),
        .valid_d (valid_d)
    );

    assign bg_addr  = pixel_addr(pos_y + Y_W'(row), pos_x + X_W'(col));
    assign spr_addr = SPR_AW'({row, col});

    // Signed step so a move past the left/top edge is visible before clamping
    always_comb begin
        nx_c = $signed(11'(pos_x));
        ny_c = $signed(11'(pos_y));
        nx_c = dir_q[1] ? nx_c + STEP_S : nx_c - STEP_S;
        ny_c = dir_q[0] ? ny_c - STEP_S : ny_c + STEP_S;
        if (nx_c[10])           next_x_c = '0;
        else if (nx_c > MAX_X_S) next_x_c = X_W'(MAX_X);
        else                     next_x_c = X_W'(nx_c);
        if (ny_c[10])           next_y_c = '0;
        else if (ny_c > MAX_Y_S) next_y_c = Y_W'(MAX_Y);
        else                     next_y_c = Y_W'(ny_c);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= S_INIT_DRAW;
            pos_x  <= X_W'(X_START);
            pos_y  <= Y_W'(Y_START);
            dir_q  <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            done <= 1'b0;

            // Pixel output stage runs off the delayed scan so it drains past the state change
            if (valid_d) begin
                x <= pos_x + X_W'(col_d);
                y <= pos_y + Y_W'(row_d);
                if (state == S_ERASE) begin
                    colour <= bg_data;
                    plot   <= 1'b1;
                end else begin
                    colour <= spr_data;
                    plot   <= (spr_data != TRANSPARENT);
                end
            end else begin
                plot <= 1'b0;
            end

            case (state)
                S_INIT_DRAW, S_DRAW: begin
                    if (!scan_active) begin
                        state <= S_FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req) begin
                        state <= S_ERASE;
                        dir_q <= dir;
                        busy  <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (!scan_active) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    state <= S_DRAW;
                    pos_x <= next_x_c;
                    pos_y <= next_y_c;
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_redraw_engine.sv
// Directed bench for sprite_redraw_engine: ROM models, pixel capture and
// scenario tasks with hand-derived expected positions, pixel lists and latency.
module tb_sprite_redraw_engine;

    typedef struct packed {
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    logic        clock  = 1'b0;
    logic        resetn = 1'b1;
    logic        req    = 1'b0;
    logic [1:0]  dir    = 2'b00;
    logic        busy, done, plot;
    logic [16:0] bg_addr;
    logic [2:0]  bg_data, spr_data, colour;
    logic [5:0]  spr_addr;
    logic [8:0]  x, pos_x;
    logic [7:0]  y, pos_y;

    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t got[$];
    pix_t exp_q[$];

    // Start at y=2 so both edge clamps and the (100,50) scenario are reachable on a 4-pixel grid
    sprite_redraw_engine #(
        .X_START (0),
        .Y_START (2)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .bg_addr  (bg_addr),
        .bg_data  (bg_data),
        .spr_addr (spr_addr),
        .spr_data (spr_data),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .pos_x    (pos_x),
        .pos_y    (pos_y)
    );

    always #10 clock = ~clock;

    function automatic logic [2:0] bg_rom(input int a);
        return 3'(a ^ (a >> 3) ^ (a >> 7));
    endfunction

    function automatic logic [2:0] spr_rom(input int a);
        return (a % 7 == 3) ? 3'b101 : 3'((a * 3) ^ (a >> 2));
    endfunction

    always @(posedge clock) begin
        bg_data  <= bg_rom(int'(bg_addr));
        spr_data <= spr_rom(int'(spr_addr));
    end

    task automatic add_erase(input int px, input int py);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_q.push_back({9'(px + c), 8'(py + r), bg_rom((py + r) * 320 + px + c)});
    endtask

    task automatic add_draw(input int px, input int py);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (spr_rom(r * 8 + c) != 3'b101)
                    exp_q.push_back({9'(px + c), 8'(py + r), spr_rom(r * 8 + c)});
    endtask

    function automatic int first_diff();
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Captures plotted pixels until done; cycles counts from the acceptance edge
    task automatic wait_done(input int start_cycles, output int cycles, output bit seen);
        cycles = start_cycles;
        seen   = 1'b0;
        got.delete();
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            if (plot) got.push_back({x, y, colour});
            if (done) seen = 1'b1;
            else begin
                @(posedge clock);
                cycles++;
            end
        end
    endtask

    task automatic accept(input logic [1:0] d, input bit hold);
        @(negedge clock);
        dir = d;
        req = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) req = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] d);
        int cyc;
        bit seen;
        accept(d, 1'b0);
        wait_done(1, cyc, seen);
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL move_timeout: dir %b, no done within bound", d); end
    endtask

    task automatic test_reset();
        int cyc, idx;
        bit seen;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %b expected 0", plot); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        n_checks++; if ({x, y, colour} !== 20'd0) begin n_fail++; $display("FAIL reset_xyc: got %0d,%0d,%0d expected 0,0,0", x, y, colour); end
        n_checks++; if (pos_x !== 9'd0 || pos_y !== 8'd2) begin n_fail++; $display("FAIL reset_pos: got %0d,%0d expected 0,2", pos_x, pos_y); end
        exp_q.delete();
        add_draw(0, 2);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock);
        wait_done(1, cyc, seen);
        n_checks++; if (!seen || cyc != 65) begin n_fail++; $display("FAIL init_latency: got %0d (seen %b) expected 65", cyc, seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_at_done: got %b expected 0", busy); end
        idx = first_diff();
        n_checks++; if (idx >= 0) begin n_fail++; $display("FAIL init_pixels: first diff at %0d, got %0d pixels expected %0d", idx, got.size(), exp_q.size()); end
        n_checks++; if (pos_x !== 9'd0 || pos_y !== 8'd2) begin n_fail++; $display("FAIL init_pos: got %0d,%0d expected 0,2", pos_x, pos_y); end
    endtask

    task automatic test_walk_to_start();
        do_move(2'b00);
        n_checks++; if (pos_x !== 9'd0 || pos_y !== 8'd6) begin n_fail++; $display("FAIL clamp_left_x: got %0d,%0d expected 0,6", pos_x, pos_y); end
        for (int i = 0; i < 11; i++) do_move(2'b10);
        for (int i = 0; i < 14; i++) do_move((i % 2 == 0) ? 2'b11 : 2'b10);
        n_checks++; if (pos_x !== 9'd100 || pos_y !== 8'd50) begin n_fail++; $display("FAIL walk_pos: got %0d,%0d expected 100,50", pos_x, pos_y); end
    endtask

    task automatic test_move_right_down();
        int cyc, idx;
        bit seen;
        exp_q.delete();
        add_erase(100, 50);
        add_draw(104, 54);
        accept(2'b10, 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL move_busy_after_accept: got %b expected 1", busy); end
        wait_done(1, cyc, seen);
        n_checks++; if (!seen || cyc != 132) begin n_fail++; $display("FAIL move_latency: got %0d (seen %b) expected 132", cyc, seen); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL move_busy_at_done: got %b expected 0", busy); end
        idx = first_diff();
        n_checks++; if (idx >= 0) begin n_fail++; $display("FAIL move_pixels: first diff at %0d, got %0d pixels expected %0d", idx, got.size(), exp_q.size()); end
        n_checks++; if (pos_x !== 9'd104 || pos_y !== 8'd54) begin n_fail++; $display("FAIL move_pos: got %0d,%0d expected 104,54", pos_x, pos_y); end
        @(negedge clock);
        n_checks++; if (done !== 1'b0 || plot !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got done %b plot %b expected 0 0", done, plot); end
    endtask

    task automatic test_clamp_right_down();
        int cyc, idx;
        bit seen;
        for (int i = 0; i < 44; i++) do_move(2'b10);
        for (int i = 0; i < 8; i++) do_move((i % 2 == 0) ? 2'b11 : 2'b10);
        n_checks++; if (pos_x !== 9'd312 || pos_y !== 8'd230) begin n_fail++; $display("FAIL walk_edge_pos: got %0d,%0d expected 312,230", pos_x, pos_y); end
        exp_q.delete();
        add_erase(312, 230);
        add_draw(312, 232);
        accept(2'b10, 1'b0);
        wait_done(1, cyc, seen);
        n_checks++; if (!seen || cyc != 132) begin n_fail++; $display("FAIL clamp_rd_latency: got %0d (seen %b) expected 132", cyc, seen); end
        idx = first_diff();
        n_checks++; if (idx >= 0) begin n_fail++; $display("FAIL clamp_rd_pixels: first diff at %0d, got %0d pixels expected %0d", idx, got.size(), exp_q.size()); end
        n_checks++; if (pos_x !== 9'd312 || pos_y !== 8'd232) begin n_fail++; $display("FAIL clamp_rd_pos: got %0d,%0d expected 312,232", pos_x, pos_y); end
    endtask

    task automatic test_reset_mid_erase();
        int cyc, idx;
        bit seen;
        accept(2'b01, 1'b0);
        repeat (20) @(posedge clock);
        #2;
        n_checks++; if (plot !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_erase_active: got plot %b busy %b expected 1 1", plot, busy); end
        resetn = 1'b0;
        #1;
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL async_plot: got %b expected 0", plot); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL async_flags: got busy %b done %b expected 1 0", busy, done); end
        n_checks++; if (pos_x !== 9'd0 || pos_y !== 8'd2) begin n_fail++; $display("FAIL async_pos: got %0d,%0d expected 0,2", pos_x, pos_y); end
        n_checks++; if ({x, y, colour} !== 20'd0) begin n_fail++; $display("FAIL async_xyc: got %0d,%0d,%0d expected 0,0,0", x, y, colour); end
        exp_q.delete();
        add_draw(0, 2);
        @(negedge clock) resetn = 1'b1;
        @(posedge clock);
        wait_done(1, cyc, seen);
        n_checks++; if (!seen || cyc != 65) begin n_fail++; $display("FAIL rerun_latency: got %0d (seen %b) expected 65", cyc, seen); end
        idx = first_diff();
        n_checks++; if (idx >= 0) begin n_fail++; $display("FAIL rerun_pixels: first diff at %0d, got %0d pixels expected %0d", idx, got.size(), exp_q.size()); end
    endtask

    task automatic test_clamp_left_up();
        int cyc, idx;
        bit seen;
        exp_q.delete();
        add_erase(0, 2);
        add_draw(0, 0);
        accept(2'b01, 1'b0);
        wait_done(1, cyc, seen);
        n_checks++; if (!seen || cyc != 132) begin n_fail++; $display("FAIL clamp_lu_latency: got %0d (seen %b) expected 132", cyc, seen); end
        idx = first_diff();
        n_checks++; if (idx >= 0) begin n_fail++; $display("FAIL clamp_lu_pixels: first diff at %0d, got %0d pixels expected %0d", idx, got.size(), exp_q.size()); end
        n_checks++; if (pos_x !== 9'd0 || pos_y !== 8'd0) begin n_fail++; $display("FAIL clamp_lu_pos: got %0d,%0d expected 0,0", pos_x, pos_y); end
    endtask

    task automatic test_req_held();
        int cyc;
        bit seen;
        accept(2'b10, 1'b1);
        wait_done(1, cyc, seen);
        req = 1'b0;
        n_checks++; if (!seen || cyc != 132) begin n_fail++; $display("FAIL held_latency: got %0d (seen %b) expected 132", cyc, seen); end
        repeat (5) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_requeue: got busy %b expected 0", busy); end
        n_checks++; if (pos_x !== 9'd4 || pos_y !== 8'd4) begin n_fail++; $display("FAIL held_pos: got %0d,%0d expected 4,4", pos_x, pos_y); end
    endtask

    task automatic test_busy_pulse();
        int cyc;
        bit seen;
        accept(2'b10, 1'b0);
        repeat (30) @(posedge clock);
        @(negedge clock);
        dir = 2'b01;
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        wait_done(0, cyc, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL pulse_timeout: no done within bound"); end
        repeat (5) @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse_queued: got busy %b expected 0", busy); end
        n_checks++; if (pos_x !== 9'd8 || pos_y !== 8'd8) begin n_fail++; $display("FAIL pulse_pos: got %0d,%0d expected 8,8", pos_x, pos_y); end
    endtask

    initial begin
        test_reset();
        test_walk_to_start();
        test_move_right_down();
        test_clamp_right_down();
        test_reset_mid_erase();
        test_clamp_left_up();
        test_req_held();
        test_busy_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
